// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl_pkg                                                 |
// | Shared state encodings and control-word helpers for the hazard sequencer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pipeline_hazard_ctrl_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE     = ctrl_t'(8'b0000_0000);
  localparam ctrl_t CTRL_HOLD     = ctrl_t'(8'b0000_0001);
  localparam ctrl_t CTRL_NORMAL   = ctrl_t'(8'b1111_0000);
  localparam ctrl_t CTRL_REDIRECT = ctrl_t'(8'b1111_1110);
  // Load-use: freeze PC and IF/ID, push a bubble into ID/EXE, let EXE advance.
  localparam ctrl_t CTRL_LOADUSE  = ctrl_t'(8'b0011_0100);

  // Control word when the memory stage is not holding the pipeline.
  function automatic ctrl_t run_ctrl(input logic redirect, input logic load_use);
    ctrl_t c;
    if (redirect) begin
      c = CTRL_REDIRECT;
    end else if (load_use) begin
      c = CTRL_LOADUSE;
    end else begin
      c = CTRL_NORMAL;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl_hazard_detect                                       |
// | Combinational load-use comparator between ID sources and EXE load dest   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use1_i,
  input  logic              id_use2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memread_i,
  output logic              load_use_o
);

  logic w_rd_nz;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign w_rd_nz    = |ex_rd_i;
  assign w_rs1_hit  = id_use1_i && (id_rs1_i == ex_rd_i);
  assign w_rs2_hit  = id_use2_i && (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_memread_i && w_rd_nz && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl                                                     |
// | Stall/flush sequencer: load-use, MEM redirects, dmem wait and timeout    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEFAULT,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use1_i,
  input  logic              id_use2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memread_i,
  input  logic              mem_memread_i,
  input  logic              mem_memwrite_i,
  input  logic              mem_redirect_i,
  input  logic              dmem_ready_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              idex_en_o,
  output logic              exmem_en_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              exmem_flush_o,
  output logic              memwb_bubble_o,
  output logic              dmem_req_o,
  output logic              mem_timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int               WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STALL_MAX = '1;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic  w_acc;
  logic  w_load_use;
  ctrl_t w_ctrl;

  assign w_acc = mem_memread_i || mem_memwrite_i;

  pipeline_hazard_ctrl_hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use1_i    (id_use1_i),
    .id_use2_i    (id_use2_i),
    .ex_rd_i      (ex_rd_i),
    .ex_memread_i (ex_memread_i),
    .load_use_o   (w_load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      ST_RUN: begin
        if (w_acc && !dmem_ready_i) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            state_d   = ST_HALT;
            timeout_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Inputs are frozen while held, so a pending redirect is applied on release.
  always_comb begin
    w_ctrl = CTRL_IDLE;
    unique case (state_q)
      ST_RUN:      w_ctrl = (w_acc && !dmem_ready_i) ? CTRL_HOLD
                                                    : run_ctrl(mem_redirect_i, w_load_use);
      ST_MEM_WAIT: w_ctrl = dmem_ready_i ? run_ctrl(mem_redirect_i, w_load_use) : CTRL_HOLD;
      ST_HALT:     w_ctrl = CTRL_HOLD;
      default:     w_ctrl = CTRL_HOLD;
    endcase
    if (rst) begin
      w_ctrl = CTRL_IDLE;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!w_ctrl.pc_en && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign pc_en_o        = w_ctrl.pc_en;
  assign ifid_en_o      = w_ctrl.ifid_en;
  assign idex_en_o      = w_ctrl.idex_en;
  assign exmem_en_o     = w_ctrl.exmem_en;
  assign ifid_flush_o   = w_ctrl.ifid_flush;
  assign idex_flush_o   = w_ctrl.idex_flush;
  assign exmem_flush_o  = w_ctrl.exmem_flush;
  assign memwb_bubble_o = w_ctrl.memwb_bubble;
  assign dmem_req_o     = !rst && (state_q != ST_HALT) && w_acc;
  assign mem_timeout_o  = timeout_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule
`default_nettype wire
